// File: rtl/mips_pkg.sv
// Shared MIPS definitions: mnemonics, opcode/funct constants and the loader FSM state type.
package mips_pkg;

  typedef enum logic [4:0] {
    NEM_ZERO    = 5'd0,
    NEM_ADD     = 5'd1,
    NEM_ADDI    = 5'd2,
    NEM_ADDIU   = 5'd3,
    NEM_AND     = 5'd4,
    NEM_ABS     = 5'd5,
    NEM_BEQ     = 5'd6,
    NEM_JUMP    = 5'd7,
    NEM_LW      = 5'd8,
    NEM_OR      = 5'd9,
    NEM_SLT     = 5'd10,
    NEM_SUB     = 5'd11,
    NEM_SW      = 5'd12,
    NEM_XOR     = 5'd13,
    NEM_ILLEGAL = 5'd31
  } t_instr_pnmen;

  localparam logic [5:0] OP_ZERO  = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ABS   = 6'h1C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [4:0] SHAMT_ZERO = 5'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } t_enc_state;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_ZERO, rs, rt, rd, SHAMT_ZERO, funct};
  endfunction

endpackage

// File: rtl/mips_instr_encoder_loader_if.sv
// Host-side request/control bus and instruction-memory port of the program loader.
interface mips_instr_encoder_loader_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
) ();
  import mips_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              req_valid;
  logic              req_ready;
  t_instr_pnmen      req_pnem;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [31:0]       imem_rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  words_written;

  modport slave (
    input  start, base_addr, count, req_valid, req_pnem, req_rs, req_rt, req_rd,
           req_imm, req_target, imem_rdata,
    output req_ready, imem_we, imem_addr, imem_wdata, busy, done, err, words_written
  );

  modport master (
    output start, base_addr, count, req_valid, req_pnem, req_rs, req_rt, req_rd,
           req_imm, req_target, imem_rdata,
    input  req_ready, imem_we, imem_addr, imem_wdata, busy, done, err, words_written
  );

endinterface

// File: rtl/mips_instr_pack.sv
// Combinational mnemonic + operand fields -> 32-bit MIPS word; flags mnemonics it cannot encode.
module mips_instr_pack
  import mips_pkg::*;
(
  input  t_instr_pnmen pnem,
  input  logic [4:0]   rs,
  input  logic [4:0]   rt,
  input  logic [4:0]   rd,
  input  logic [15:0]  imm,
  input  logic [25:0]  target,
  output logic [31:0]  word,
  output logic         illegal
);

  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (pnem)
      NEM_ADD:   word = r_word(rs, rt, rd, FUNCT_ADD);
      NEM_AND:   word = r_word(rs, rt, rd, FUNCT_AND);
      NEM_OR:    word = r_word(rs, rt, rd, FUNCT_OR);
      NEM_SLT:   word = r_word(rs, rt, rd, FUNCT_SLT);
      NEM_SUB:   word = r_word(rs, rt, rd, FUNCT_SUB);
      NEM_XOR:   word = r_word(rs, rt, rd, FUNCT_XOR);
      NEM_ADDI:  word = {OP_ADDI, rs, rt, imm};
      NEM_ADDIU: word = {OP_ADDIU, rs, rt, imm};
      NEM_BEQ:   word = {OP_BEQ, rs, rt, imm};
      NEM_LW:    word = {OP_LW, rs, rt, imm};
      NEM_SW:    word = {OP_SW, rs, rt, imm};
      NEM_JUMP:  word = {OP_JUMP, target};
      NEM_ABS:   word = {OP_ABS, rs, rt, 16'h0};
      NEM_ZERO:  word = 32'h0;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder_loader.sv
// Encodes instruction requests and writes them sequentially into instruction memory.
// Optional write-then-read verification is enabled with MIPS_ENC_READBACK_EN.
module mips_instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
) (
  input logic                       clk,
  input logic                       rst,
  mips_instr_encoder_loader_if.slave bus
);

  t_enc_state        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_out_reg;
  logic [CNT_W-1:0]  remaining_reg;
  logic [CNT_W-1:0]  words_reg;
  logic [31:0]       wdata_reg;
  logic              we_reg;
  logic              err_reg;
  logic              ready;
  logic              accept;
  logic              start_ok;
  logic [31:0]       enc_word;
  logic              enc_illegal;

  mips_instr_pack u_pack (
    .pnem    (bus.req_pnem),
    .rs      (bus.req_rs),
    .rt      (bus.req_rt),
    .rd      (bus.req_rd),
    .imm     (bus.req_imm),
    .target  (bus.req_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = (bus.count == '0) ? DONE : LOAD;
      end
      LOAD: begin
`ifdef MIPS_ENC_READBACK_EN
        ready = (remaining_reg != '0) && !we_reg;
        if (we_reg) state_next = VERIFY;
`else
        // remaining only reaches zero through an accept, so this cycle carries the final write
        ready = (remaining_reg != '0);
        if (remaining_reg == '0) state_next = DONE;
`endif
      end
`ifdef MIPS_ENC_READBACK_EN
      VERIFY: state_next = (remaining_reg == '0) ? DONE : LOAD;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept   = ready & bus.req_valid;
  assign start_ok = (state_reg == IDLE) & bus.start;

`ifdef MIPS_ENC_READBACK_EN
  logic chk_reg;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.imem_rdata;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg      <= '0;
      addr_out_reg  <= '0;
      remaining_reg <= '0;
      words_reg     <= '0;
      wdata_reg     <= 32'h0;
      we_reg        <= 1'b0;
      err_reg       <= 1'b0;
`ifdef MIPS_ENC_READBACK_EN
      chk_reg       <= 1'b0;
`endif
    end else begin
      we_reg <= accept;
      if (start_ok) begin
        addr_reg      <= bus.base_addr;
        remaining_reg <= bus.count;
        err_reg       <= 1'b0;
        words_reg     <= '0;
      end
      if (accept) begin
        wdata_reg     <= enc_word;
        addr_out_reg  <= addr_reg;
        addr_reg      <= addr_reg + 1'b1;
        remaining_reg <= remaining_reg - 1'b1;
        words_reg     <= words_reg + 1'b1;
        if (enc_illegal) err_reg <= 1'b1;
      end
`ifdef MIPS_ENC_READBACK_EN
      // read issued in VERIFY returns one cycle later; wdata_reg still holds the checked word
      chk_reg <= (state_reg == VERIFY);
      if (chk_reg && (bus.imem_rdata != wdata_reg)) err_reg <= 1'b1;
`endif
    end
  end

  assign bus.req_ready     = ready;
  assign bus.imem_we       = we_reg;
  assign bus.imem_addr     = addr_out_reg;
  assign bus.imem_wdata    = wdata_reg;
  assign bus.busy          = (state_reg != IDLE);
  assign bus.done          = (state_reg == DONE);
  assign bus.err           = err_reg;
  assign bus.words_written = words_reg;

endmodule
